rbcp_axil_bridge: RTL

Bridges the SiTCP RBCP byte-wide register bus to an AXI4-Lite master port.
- Generalised in data width (32/64) and byte order.
- Single-outstanding transaction FSM with AXI response checking and a response timeout.
- A late or stale response can never be consumed by a later RBCP transaction.
- Sits between the SiTCP core and the AXI interconnect of the register map.

---
 rtl/rbcp_axil_pkg.sv | 39 +++
 rtl/rbcp_lane_mux.sv | 38 +++
 rtl/rbcp_axil_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rbcp_axil_pkg.sv
// Shared types and helpers for the RBCP to AXI4-Lite bridge: FSM states,
// AXI response codes, byte-lane selection and saturating counter helpers.
package rbcp_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_ACK   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte lane k addressed by the RBCP offset within one AXI beat.
  function automatic logic [2:0] lane_k(input logic [2:0] addr_lsbs, input int nb,
                                        input bit big_endian);
    logic [2:0] last;
    last = 3'(nb - 1);
    if (big_endian) begin
      lane_k = last - addr_lsbs;
    end else begin
      lane_k = addr_lsbs;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/rbcp_lane_mux.sv
// Maps one RBCP byte onto an AXI beat: write strobe and replicated write data
// for the selected lane, and extraction of that same lane from read data.
module rbcp_lane_mux
  import rbcp_axil_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1,
  localparam int NB        = DATA_W / 8,
  localparam int LW        = $clog2(NB)
) (
  input  logic [LW-1:0]     lane,
  input  logic [7:0]        wd,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        rd_byte
);

  logic [2:0] k_s;

  assign k_s   = lane_k(3'(lane), NB, BIG_ENDIAN != 0);
  assign wdata = {NB{wd}};

  // one-hot strobe and read byte select share the same lane index
  always_comb begin
    wstrb   = {NB{1'b0}};
    rd_byte = 8'd0;
    for (int i = 0; i < NB; i++) begin
      if (i == int'(k_s)) begin
        wstrb[i] = 1'b1;
        rd_byte  = rdata[8*i +: 8];
      end else begin
        wstrb[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rbcp_axil_bridge.sv
// SiTCP RBCP byte bus to AXI4-Lite master, one transaction in flight, with
// response checking, a response timeout and discard of late responses.
module rbcp_axil_bridge
  import rbcp_axil_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BIG_ENDIAN  = 1,
  parameter int TIMEOUT_CYC = 1023,
  parameter int ACK_ON_ERR  = 0,
  localparam int NB         = DATA_W / 8,
  localparam int LW         = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rbcp_act,
  input  logic [31:0]       rbcp_addr,
  input  logic [7:0]        rbcp_wd,
  input  logic              rbcp_we,
  input  logic              rbcp_re,
  output logic              rbcp_ack,
  output logic [7:0]        rbcp_rd,
  output logic [31:0]       m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [NB-1:0]     m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [31:0]       m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  state_e            st_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [7:0]        rd_q;
  logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q, ack_q;
  logic [7:0]        err_q;
  logic [15:0]       tmo_q;
  logic [7:0]        stale_b_q, stale_r_q;

  logic [LW-1:0]     lane_s;
  logic [NB-1:0]     mux_wstrb_s;
  logic [DATA_W-1:0] mux_wdata_s;
  logic [7:0]        mux_rd_s;
  logic              tmo_hit_s;
  logic              unused_s;

  // In IDLE the strobe is latched from the live address, afterwards from the latch
  assign lane_s    = (st_q == ST_IDLE) ? rbcp_addr[LW-1:0] : addr_q[LW-1:0];
  assign tmo_hit_s = (tmo_q == TMO_LIM);
  assign unused_s  = rbcp_act;

  rbcp_lane_mux #(
    .DATA_W    (DATA_W),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_mux (
    .lane   (lane_s),
    .wd     (rbcp_wd),
    .rdata  (m_axi_rdata),
    .wstrb  (mux_wstrb_s),
    .wdata  (mux_wdata_s),
    .rd_byte(mux_rd_s)
  );

  // response timer: zero in IDLE, counts and holds at the limit elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 16'd0;
    end else if (st_q == ST_IDLE) begin
      tmo_q <= 16'd0;
    end else if (!tmo_hit_s) begin
      tmo_q <= tmo_q + 16'd1;
    end else begin
      tmo_q <= tmo_q;
    end
  end

  // transaction sequencer; stale_* count abandoned responses still owed by the slave
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= {DATA_W{1'b0}};
      wstrb_q   <= {NB{1'b0}};
      rd_q      <= 8'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b1;
      rready_q  <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 8'd0;
      stale_b_q <= 8'd0;
      stale_r_q <= 8'd0;
    end else begin
      ack_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (m_axi_bvalid && stale_b_q != 8'd0) stale_b_q <= stale_b_q - 8'd1;
          if (m_axi_rvalid && stale_r_q != 8'd0) stale_r_q <= stale_r_q - 8'd1;
          if (rbcp_we) begin
            addr_q    <= rbcp_addr;
            wdata_q   <= mux_wdata_s;
            wstrb_q   <= mux_wstrb_s;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            st_q      <= ST_WADDR;
          end else if (rbcp_re) begin
            addr_q    <= rbcp_addr;
            arvalid_q <= 1'b1;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            st_q      <= ST_RADDR;
          end
        end
        ST_WADDR: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q <= 1'b1;
            st_q     <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid && stale_b_q != 8'd0) begin
            stale_b_q <= stale_b_q - 8'd1;
          end else if (m_axi_bvalid) begin
            ack_q    <= (m_axi_bresp == RESP_OKAY) || (ACK_ON_ERR != 0);
            if (m_axi_bresp != RESP_OKAY) err_q <= sat_inc8(err_q);
            bready_q <= 1'b0;
            st_q     <= ST_ACK;
          end else if (tmo_hit_s) begin
            err_q     <= sat_inc8(err_q);
            stale_b_q <= sat_inc8(stale_b_q);
            rready_q  <= 1'b1;
            st_q      <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            st_q      <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid && stale_r_q != 8'd0) begin
            stale_r_q <= stale_r_q - 8'd1;
          end else if (m_axi_rvalid) begin
            ack_q    <= (m_axi_rresp == RESP_OKAY) || (ACK_ON_ERR != 0);
            rd_q     <= (m_axi_rresp == RESP_OKAY) ? mux_rd_s : 8'h00;
            if (m_axi_rresp != RESP_OKAY) err_q <= sat_inc8(err_q);
            rready_q <= 1'b0;
            st_q     <= ST_ACK;
          end else if (tmo_hit_s) begin
            err_q     <= sat_inc8(err_q);
            stale_r_q <= sat_inc8(stale_r_q);
            bready_q  <= 1'b1;
            st_q      <= ST_IDLE;
          end
        end
        ST_ACK: begin
          bready_q <= 1'b1;
          rready_q <= 1'b1;
          st_q     <= ST_IDLE;
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          arvalid_q <= 1'b0;
          bready_q  <= 1'b1;
          rready_q  <= 1'b1;
          st_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign rbcp_ack      = ack_q;
  assign rbcp_rd       = rd_q;
  assign m_axi_awaddr  = {addr_q[31:LW], {LW{1'b0}}};
  assign m_axi_araddr  = {addr_q[31:LW], {LW{1'b0}}};
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign err_cnt       = err_q;
  assign busy          = (st_q != ST_IDLE);

endmodule
